// File: rtl/score_note_writer.sv
// score_note_writer: writer end of the score buffer.
// Turns the pitch detector's note strobe into one 6-bit code per eighth-note
// slot, committed into a flat array of SLOTS entries that the staff renderer
// reads directly. Supports clear-then-record, stop, optional wrap-around.
module score_note_writer #(
  parameter int TICKS_PER_EIGHTH = 18_562_500,
  parameter int SLOTS            = 160,
  parameter bit WRAP             = 1'b0
) (
  input  logic                  pixel_clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic                  note_valid_in,
  input  logic [5:0]            note_in,
  output logic [SLOTS-1:0][5:0] notes_out,
  output logic [7:0]            write_ptr_out,
  output logic                  recording_out,
  output logic                  busy_out,
  output logic                  full_out,
  output logic                  tick_out
);

  localparam int             TW        = $clog2(TICKS_PER_EIGHTH);
  localparam logic [TW-1:0]  LAST_TICK = TW'(TICKS_PER_EIGHTH - 1);
  localparam logic [7:0]     LAST_SLOT = 8'(SLOTS - 1);
  localparam logic [5:0]     TOP_NOTE  = 6'b110101;

  typedef enum logic [1:0] {IDLE, CLEAR, RECORD, FULL} state_t;

  state_t            state;
  state_t            state_next;
  logic [TW-1:0]     tick_count;
  logic [7:0]        clr_ptr;
  logic [7:0]        write_ptr;
  logic [5:0]        latch_note;
  logic              latch_full;
  logic              commit;
  logic [5:0]        clean_note;
  logic [5:0]        commit_note;
  logic [SLOTS-1:0]  clr_hit;
  logic [SLOTS-1:0]  wr_hit;

  // Out-of-range sounding codes and rests both collapse to the rest code.
  function automatic logic [5:0] sanitize(input logic [5:0] code);
    return (code[5] && (code <= TOP_NOTE)) ? code : 6'b000000;
  endfunction

  assign clean_note = sanitize(note_in);

  // start and stop both pre-empt a commit that falls on the same cycle.
  assign commit = (state == RECORD) && !start_in && !stop_in && (tick_count == LAST_TICK);

  // A strobe on the commit cycle itself bypasses the latch.
  assign commit_note = note_valid_in ? clean_note :
                       (latch_full ? latch_note : 6'b000000);

  assign write_ptr_out = write_ptr;

  // Per-slot write enables: clearing sweep or the current record slot.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot_en
      assign clr_hit[gi] = (state == CLEAR) && (clr_ptr == 8'(gi));
      assign wr_hit[gi]  = commit && (write_ptr == 8'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start wins over stop, CLEAR ignores both.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start_in) state_next = CLEAR;
      CLEAR:  if (clr_ptr == LAST_SLOT) state_next = RECORD;
      RECORD: begin
        if (start_in)                                      state_next = CLEAR;
        else if (stop_in)                                  state_next = IDLE;
        else if (commit && (write_ptr == LAST_SLOT) && !WRAP) state_next = FULL;
      end
      FULL: begin
        if (start_in)     state_next = CLEAR;
        else if (stop_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    recording_out = (state == RECORD);
    busy_out      = (state == CLEAR);
    full_out      = (state == FULL);
    tick_out      = commit;
  end

  // Eighth-note tick counter; only runs while staying in RECORD.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)
      tick_count <= '0;
    else if ((state == RECORD) && (state_next == RECORD) && (tick_count != LAST_TICK))
      tick_count <= tick_count + TW'(1);
    else
      tick_count <= '0;
  end

  // Clear sweep pointer, parked at 0 outside CLEAR so each sweep starts fresh.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)
      clr_ptr <= 8'd0;
    else if ((state == CLEAR) && (clr_ptr != LAST_SLOT))
      clr_ptr <= clr_ptr + 8'd1;
    else
      clr_ptr <= 8'd0;
  end

  // Write pointer: rewound at end of clear, advanced on commit, held at the
  // last slot when the buffer fills without wrap.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in)
      write_ptr <= 8'd0;
    else if ((state == CLEAR) && (clr_ptr == LAST_SLOT))
      write_ptr <= 8'd0;
    else if (commit && (state_next == RECORD))
      write_ptr <= (write_ptr == LAST_SLOT) ? 8'd0 : write_ptr + 8'd1;
  end

  // Slot latch: last sanitized strobe of the slot; emptied on commit or exit.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      latch_note <= 6'b000000;
      latch_full <= 1'b0;
    end else if ((state != RECORD) || start_in || stop_in || commit) begin
      latch_note <= 6'b000000;
      latch_full <= 1'b0;
    end else if (note_valid_in) begin
      latch_note <= clean_note;
      latch_full <= 1'b1;
    end
  end

  // Score array: at most one slot changes per cycle.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < SLOTS; i++) notes_out[i] <= 6'b000000;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (clr_hit[i])     notes_out[i] <= 6'b000000;
        else if (wr_hit[i]) notes_out[i] <= commit_note;
      end
    end
  end

endmodule
